// File: rtl/mem_access_stage.sv
// Memory-access stage: issues aligned loads/stores on the data bus through a
// request/grant/response handshake, stalls upstream while a transaction is
// outstanding, and registers the write-back signals (acts as MEM/WB register).
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_c,
  input  logic [31:0] mem_rD2,
  input  logic [31:0] mem_ext,
  input  logic [31:0] mem_pc4,
  input  logic        mem_ram_we,
  input  logic        mem_ram_re,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        mem_rf_we,
  input  logic [1:0]  mem_rf_wsel,
  input  logic [4:0]  mem_wR,
  output logic        mem_stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output logic        wb_rf_we,
  output logic [4:0]  wb_wR,
  output logic [31:0] wb_wD,
  output logic [31:0] wb_pc4,
  output logic        wb_misalign,
  output logic        wb_bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   wait_cnt;

  logic            access;
  logic            is_byte;
  logic            is_half;
  logic            misaligned;
  logic            bus_access;
  logic            timeout;
  logic            done;
  logic            bus_err;
  logic            retire;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     load_data;
  logic [31:0]     wb_sel_data;

  // Decode of the held instruction: access type, alignment and completion.
  assign access     = mem_valid & (mem_ram_we | mem_ram_re);
  assign is_byte    = (mem_size == 2'd0);
  assign is_half    = (mem_size == 2'd1);
  assign misaligned = access & ((is_half & mem_c[0]) |
                                (~is_byte & ~is_half & (mem_c[1:0] != 2'b00)));
  assign bus_access = access & ~misaligned;
  assign timeout    = (state == S_WAIT) & (wait_cnt == CW'(TIMEOUT - 1));
  assign done       = (state == S_WAIT) & (dbus_rvalid | timeout);
  assign bus_err    = bus_access & (state == S_WAIT) & ~dbus_rvalid & timeout;
  assign mem_stall  = bus_access & ~done;
  assign retire     = mem_valid & ~mem_stall;

  assign dbus_req   = bus_access & ((state == S_IDLE) | (state == S_REQ));
  assign dbus_addr  = {mem_c[31:2], 2'b00};

  // Store lane replication and byte enables; loads read the full word.
  always_comb begin
    dbus_we    = bus_access & mem_ram_we;
    dbus_wdata = mem_rD2;
    dbus_be    = 4'b1111;
    if (mem_ram_we) begin
      if (is_byte) begin
        dbus_wdata = {4{mem_rD2[7:0]}};
        dbus_be    = 4'b0001 << mem_c[1:0];
      end else if (is_half) begin
        dbus_wdata = {2{mem_rD2[15:0]}};
        dbus_be    = mem_c[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  // Extract the addressed byte/half from the read word and extend it.
  always_comb begin
    ld_byte   = dbus_rdata[7:0];
    ld_half   = mem_c[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    load_data = dbus_rdata;
    case (mem_c[1:0])
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      2'd3:    ld_byte = dbus_rdata[31:24];
      default: ld_byte = dbus_rdata[7:0];
    endcase
    if (is_byte) begin
      load_data = {{24{~mem_unsigned & ld_byte[7]}}, ld_byte};
    end else if (is_half) begin
      load_data = {{16{~mem_unsigned & ld_half[15]}}, ld_half};
    end
  end

  // Write-back data select.
  always_comb begin
    wb_sel_data = mem_c;
    case (mem_rf_wsel)
      2'd1:    wb_sel_data = load_data;
      2'd2:    wb_sel_data = mem_pc4;
      2'd3:    wb_sel_data = mem_ext;
      default: wb_sel_data = mem_c;
    endcase
  end

  // Bus handshake next-state: request until granted, then wait for a response.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus_access) state_next = dbus_gnt ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        if (!bus_access)   state_next = S_IDLE;
        else if (dbus_gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Response timeout counter: zero on WAIT entry, counts while still waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if ((state == S_WAIT) && (state_next == S_WAIT)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Write-back register: capture on retire, otherwise drop valid and hold data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid    <= 1'b0;
      wb_rf_we    <= 1'b0;
      wb_wR       <= 5'd0;
      wb_wD       <= 32'd0;
      wb_pc4      <= 32'd0;
      wb_misalign <= 1'b0;
      wb_bus_err  <= 1'b0;
    end else if (retire) begin
      wb_valid    <= 1'b1;
      wb_rf_we    <= mem_rf_we & (mem_wR != 5'd0) & ~misaligned & ~bus_err;
      wb_wR       <= mem_wR;
      wb_wD       <= wb_sel_data;
      wb_pc4      <= mem_pc4;
      wb_misalign <= misaligned;
      wb_bus_err  <= bus_err;
    end else begin
      wb_valid    <= 1'b0;
      wb_rf_we    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_bus_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then randomized instructions,
// with expected bus and write-back behaviour computed from instruction-level rules.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ram_we, mem_ram_re, mem_unsigned, mem_rf_we;
  logic [31:0] mem_c, mem_rD2, mem_ext, mem_pc4;
  logic [1:0]  mem_size, mem_rf_wsel;
  logic [4:0]  mem_wR;
  logic        mem_stall, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        wb_valid, wb_rf_we, wb_misalign, wb_bus_err;
  logic [4:0]  wb_wR;
  logic [31:0] wb_wD, wb_pc4;

  int checks = 0;
  int errors = 0;

  logic [4:0]  prev_wR;
  logic [31:0] prev_wD, prev_pc4;
  bit          wd_known;

  typedef struct {
    logic        valid, we, re, uns, rf_we;
    logic [1:0]  size, wsel;
    logic [4:0]  wR;
    logic [31:0] c, rD2, ext, pc4;
  } instr_t;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_c(mem_c), .mem_rD2(mem_rD2), .mem_ext(mem_ext),
    .mem_pc4(mem_pc4), .mem_ram_we(mem_ram_we), .mem_ram_re(mem_ram_re),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_rf_we(mem_rf_we),
    .mem_rf_wsel(mem_rf_wsel), .mem_wR(mem_wR), .mem_stall(mem_stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
    .wb_pc4(wb_pc4), .wb_misalign(wb_misalign), .wb_bus_err(wb_bus_err)
  );

  // Single comparison point: counts the check and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input instr_t i);
    mem_valid    = i.valid;
    mem_ram_we   = i.we;
    mem_ram_re   = i.re;
    mem_unsigned = i.uns;
    mem_rf_we    = i.rf_we;
    mem_size     = i.size;
    mem_rf_wsel  = i.wsel;
    mem_wR       = i.wR;
    mem_c        = i.c;
    mem_rD2      = i.rD2;
    mem_ext      = i.ext;
    mem_pc4      = i.pc4;
  endtask

  function automatic bit isAccess(instr_t i);
    return i.valid && (i.we || i.re);
  endfunction

  function automatic bit isMis(instr_t i);
    if (!isAccess(i)) return 0;
    if (i.size == 2'd0) return 0;
    if (i.size == 2'd1) return (i.c % 2) != 0;
    return (i.c % 4) != 0;
  endfunction

  function automatic logic [31:0] loadValue(instr_t i, logic [31:0] rd);
    logic [31:0] v;
    if (i.size == 2'd0) begin
      v = (rd >> (8 * (i.c % 4))) & 32'hFF;
      if (!i.uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (i.size == 2'd1) begin
      v = (rd >> (16 * ((i.c / 2) % 2))) & 32'hFFFF;
      if (!i.uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] expBe(instr_t i);
    if (!i.we || i.size >= 2'd2) return 4'hF;
    if (i.size == 2'd0) return 4'(1 << (i.c % 4));
    return ((i.c % 4) >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] expWdata(instr_t i);
    if (i.size == 2'd0) return (i.rD2 & 32'hFF) * 32'h0101_0101;
    if (i.size == 2'd1) return (i.rD2 & 32'hFFFF) * 32'h0001_0001;
    return i.rD2;
  endfunction

  function automatic logic [31:0] expWd(instr_t i, logic [31:0] rd);
    case (i.wsel)
      2'd0:    return i.c;
      2'd1:    return loadValue(i, rd);
      2'd2:    return i.pc4;
      default: return i.ext;
    endcase
  endfunction

  task automatic checkHold(input string name);
    checkOutput({name, " wb_valid"}, wb_valid, 0);
    checkOutput({name, " wb_rf_we"}, wb_rf_we, 0);
    checkOutput({name, " wb_misalign"}, wb_misalign, 0);
    checkOutput({name, " wb_bus_err"}, wb_bus_err, 0);
    checkOutput({name, " wb_wR hold"}, wb_wR, prev_wR);
    checkOutput({name, " wb_pc4 hold"}, wb_pc4, prev_pc4);
    if (wd_known) checkOutput({name, " wb_wD hold"}, wb_wD, prev_wD);
  endtask

  // One instruction from entry to retire. rv_wait = WAIT cycle carrying rvalid
  // (1 = first WAIT cycle); 0 or > TIMEOUT means the response never comes.
  // Entered and left just after a rising edge.
  task automatic runInstr(input instr_t i, input int gnt_delay, input int rv_wait,
                          input logic [31:0] rdata, input bit noise, input string name);
    bit acc, mis, bus, err;
    int wait_cycles, total;
    logic [31:0] wd;
    acc = isAccess(i);
    mis = isMis(i);
    bus = acc && !mis;
    err = bus && !(rv_wait >= 1 && rv_wait <= TIMEOUT);
    wait_cycles = err ? TIMEOUT : rv_wait;
    total = bus ? gnt_delay + 1 + wait_cycles : 1;
    applyStimulus(i);
    dbus_rdata = rdata;
    for (int cyc = 0; cyc < total; cyc++) begin
      dbus_gnt    = bus && (cyc == gnt_delay);
      dbus_rvalid = bus && !err && (cyc == gnt_delay + rv_wait);
      if (noise) begin
        if (cyc <= gnt_delay) dbus_rvalid = 1'($urandom_range(0, 1));
        else                  dbus_gnt    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      checkOutput({name, " stall"}, mem_stall, (cyc != total - 1));
      checkOutput({name, " dbus_req"}, dbus_req, (bus && cyc <= gnt_delay));
      if (bus) begin
        checkOutput({name, " dbus_addr"}, dbus_addr, i.c & 32'hFFFF_FFFC);
        checkOutput({name, " dbus_we"}, dbus_we, i.we);
        checkOutput({name, " dbus_be"}, dbus_be, expBe(i));
        if (i.we) checkOutput({name, " dbus_wdata"}, dbus_wdata, expWdata(i));
      end
      @(posedge clk);
      #1;
      if (cyc != total - 1 || !i.valid) begin
        checkHold(name);
      end else begin
        checkOutput({name, " wb_valid"}, wb_valid, 1);
        checkOutput({name, " wb_misalign"}, wb_misalign, mis);
        checkOutput({name, " wb_bus_err"}, wb_bus_err, err);
        checkOutput({name, " wb_rf_we"}, wb_rf_we, (i.rf_we && i.wR != 0 && !mis && !err));
        checkOutput({name, " wb_wR"}, wb_wR, i.wR);
        checkOutput({name, " wb_pc4"}, wb_pc4, i.pc4);
        prev_wR  = i.wR;
        prev_pc4 = i.pc4;
        if (!mis && !err) begin
          wd = expWd(i, rdata);
          checkOutput({name, " wb_wD"}, wb_wD, wd);
          prev_wD  = wd;
          wd_known = 1;
        end else begin
          wd_known = 0;
        end
      end
    end
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
  endtask

  function automatic instr_t mkInstr(bit we, bit re, logic [1:0] size, bit uns,
                                     logic [31:0] c, logic [31:0] rD2,
                                     logic [1:0] wsel, logic [4:0] wR);
    instr_t i;
    i.valid = 1; i.we = we; i.re = re; i.uns = uns; i.rf_we = 1;
    i.size = size; i.wsel = wsel; i.wR = wR; i.c = c; i.rD2 = rD2;
    i.ext = 32'hE0E0_0001; i.pc4 = 32'h0000_4004 + {c[15:0], 2'b00};
    return i;
  endfunction

  // Watchdog so the run always ends even if the sequence were to stall.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t ins;
    rst = 1'b0;
    applyStimulus(mkInstr(0, 0, 2'd0, 0, 32'd0, 32'd0, 2'd0, 5'd0));
    mem_valid = 1'b0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset wb_valid", wb_valid, 0);
    checkOutput("reset wb_rf_we", wb_rf_we, 0);
    checkOutput("reset wb_wD", wb_wD, 0);
    checkOutput("reset wb_wR", wb_wR, 0);
    checkOutput("reset wb_pc4", wb_pc4, 0);
    checkOutput("reset dbus_req", dbus_req, 0);
    checkOutput("reset stall", mem_stall, 0);
    prev_wR = 0; prev_wD = 0; prev_pc4 = 0; wd_known = 1;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed: ALU write-back");
    runInstr(mkInstr(0, 0, 2'd2, 0, 32'h1234, 32'd0, 2'd0, 5'd5), 0, 1, 32'd0, 0, "alu");
    checkOutput("alu wb_wD const", wb_wD, 32'h1234);

    $display("[TB] directed: signed byte load");
    runInstr(mkInstr(0, 1, 2'd0, 0, 32'h103, 32'd0, 2'd1, 5'd7), 0, 1, 32'h80FF_FFFF, 0, "lb");
    checkOutput("lb wb_wD const", wb_wD, 32'hFFFF_FF80);

    $display("[TB] directed: half store with delayed grant");
    runInstr(mkInstr(1, 0, 2'd1, 0, 32'h102, 32'hABCD, 2'd0, 5'd0), 3, 1, 32'd0, 0, "sh");

    $display("[TB] directed: misaligned word load");
    runInstr(mkInstr(0, 1, 2'd2, 0, 32'h2, 32'd0, 2'd1, 5'd3), 0, 1, 32'd0, 0, "lw_mis");

    $display("[TB] directed: word load timeout");
    runInstr(mkInstr(0, 1, 2'd2, 0, 32'h200, 32'd0, 2'd1, 5'd4), 0, 0, 32'h1111_2222, 0, "lw_tmo");
    runInstr(mkInstr(0, 1, 2'd2, 1, 32'h204, 32'd0, 2'd1, 5'd4), 0, 1, 32'h3333_4444, 0, "lw_after_tmo");

    $display("[TB] directed: write to x0 suppressed");
    runInstr(mkInstr(0, 0, 2'd0, 0, 32'h55, 32'd0, 2'd0, 5'd0), 0, 1, 32'd0, 0, "alu_x0");

    $display("[TB] directed: reset during WAIT");
    applyStimulus(mkInstr(0, 1, 2'd2, 0, 32'h100, 32'd0, 2'd1, 5'd9));
    dbus_gnt = 1'b1;
    @(negedge clk);
    checkOutput("rstwait req", dbus_req, 1);
    @(posedge clk);
    #1;
    dbus_gnt = 1'b0;
    @(negedge clk);
    checkOutput("rstwait in WAIT req", dbus_req, 0);
    checkOutput("rstwait in WAIT stall", mem_stall, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    mem_valid = 1'b0;
    #1;
    checkOutput("rstwait wb_valid", wb_valid, 0);
    checkOutput("rstwait wb_rf_we", wb_rf_we, 0);
    checkOutput("rstwait wb_wR", wb_wR, 0);
    checkOutput("rstwait wb_wD", wb_wD, 0);
    checkOutput("rstwait wb_pc4", wb_pc4, 0);
    checkOutput("rstwait flags", {wb_misalign, wb_bus_err}, 0);
    checkOutput("rstwait dbus_req", dbus_req, 0);
    prev_wR = 0; prev_wD = 0; prev_pc4 = 0; wd_known = 1;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    runInstr(mkInstr(0, 1, 2'd1, 1, 32'h302, 32'd0, 2'd1, 5'd12), 0, 2, 32'h8765_4321, 0, "post_rst_lhu");

    $display("[TB] randomized instructions");
    for (int n = 0; n < 150; n++) begin
      int kind, gd, rv;
      kind = $urandom_range(0, 9);
      ins = mkInstr(0, 0, 2'($urandom), 1'($urandom), $urandom, $urandom,
                    2'($urandom), 5'($urandom));
      ins.rf_we = 1'($urandom);
      ins.ext   = $urandom;
      ins.pc4   = $urandom;
      if ($urandom_range(0, 1) == 0) ins.c[1:0] = 2'b00;
      if (kind <= 3)      ins.re = 1;
      else if (kind <= 6) ins.we = 1;
      else if (kind == 7) begin ins.we = 1; ins.re = 1; end
      if ($urandom_range(0, 9) == 0) ins.valid = 0;
      gd = $urandom_range(0, 3);
      rv = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 4);
      runInstr(ins, gd, rv, $urandom, ($urandom_range(0, 2) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
